// File: rtl/count_sched.sv
// -----------------------------------------------------------------------------
// count_sched
// Round-robin scheduler sharing one WIDTH-bit up/down counter between NREQ
// requesters. A requester asks for a burst of LEN single steps in one
// direction. The block grants the counter to one requester and sequences the
// burst, then pulses done. The counter value holds between bursts.
//
// Ports
//   clk      : system clock, all state changes on the rising edge
//   reset    : asynchronous active-low reset
//   req      : per-requester request level, held until that requester's done
//   dir      : per-requester direction (0 = up, 1 = down), sampled at grant
//   len      : per-requester burst length, requester i uses [i*LEN_W +: LEN_W]
//   grant    : one-hot owner of the counter, high during RUN only
//   busy     : high in RUN and DONE
//   done     : one-cycle completion pulse
//   done_id  : index of the completed requester, valid with done
//   aborted  : valid with done, 1 when the burst was cut short by req dropping
//   out      : shared counter value
//   wrap     : one-cycle pulse on the edge where out wraps
// -----------------------------------------------------------------------------
module count_sched #(
    parameter int NREQ  = 2,
    parameter int WIDTH = 4,
    parameter int LEN_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          dir,
    input  logic [NREQ*LEN_W-1:0]    len,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic                     aborted,
    output logic [WIDTH-1:0]         out,
    output logic                     wrap
);

    localparam int IDW = $clog2(NREQ);
    // One extra bit so the round-robin candidate index can exceed NREQ-1
    // before it is folded back.
    localparam int CW  = IDW + 1;
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Next counter value for one step in the given direction, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] step_value(
        input logic [WIDTH-1:0] cur,
        input logic             down
    );
        logic [WIDTH-1:0] res;
        if (down) begin
            res = cur - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = cur + {{(WIDTH-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    // True when one step from cur in the given direction crosses the
    // 2^WIDTH-1 / 0 boundary.
    function automatic logic step_wraps(
        input logic [WIDTH-1:0] cur,
        input logic             down
    );
        logic res;
        if (down) begin
            res = (cur == {WIDTH{1'b0}});
        end else begin
            res = (cur == {WIDTH{1'b1}});
        end
        return res;
    endfunction

    // Registered state
    state_t               r_state;
    logic [IDW-1:0]       r_last;
    logic [IDW-1:0]       r_owner;
    logic                 r_dir;
    logic [LEN_W-1:0]     r_remain;
    logic [WIDTH-1:0]     r_out;
    logic                 r_wrap;
    logic [NREQ-1:0]      r_grant;
    logic                 r_busy;
    logic                 r_done;
    logic [IDW-1:0]       r_done_id;
    logic                 r_aborted;

    // Next-state values
    state_t               w_state_nxt;
    logic [IDW-1:0]       w_last_nxt;
    logic [IDW-1:0]       w_owner_nxt;
    logic                 w_dir_nxt;
    logic [LEN_W-1:0]     w_remain_nxt;
    logic [WIDTH-1:0]     w_out_nxt;
    logic                 w_wrap_nxt;
    logic [NREQ-1:0]      w_grant_nxt;
    logic                 w_done_nxt;
    logic [IDW-1:0]       w_done_id_nxt;
    logic                 w_aborted_nxt;

    // Arbitration helpers
    logic                 w_any_req;
    logic [IDW-1:0]       w_winner;
    logic [CW-1:0]        w_cand;
    logic [LEN_W-1:0]     w_len_arr [NREQ];
    logic [LEN_W-1:0]     w_len_sel;
    logic [NREQ-1:0]      w_winner_onehot;

    // Split the packed length bus into one field per requester.
    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            w_len_arr[k] = len[k*LEN_W +: LEN_W];
        end
    end

    // Round-robin search: first asserted req starting just after r_last.
    always_comb begin
        w_any_req = 1'b0;
        w_winner  = {IDW{1'b0}};
        w_cand    = {CW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            w_cand = {1'b0, r_last} + CW'(k + 1);
            if (w_cand >= CW'(NREQ)) begin
                w_cand = w_cand - CW'(NREQ);
            end else begin
                w_cand = w_cand;
            end
            if (!w_any_req && req[w_cand[IDW-1:0]]) begin
                w_any_req = 1'b1;
                w_winner  = w_cand[IDW-1:0];
            end else begin
                w_any_req = w_any_req;
            end
        end
    end

    assign w_len_sel       = w_len_arr[w_winner];
    assign w_winner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;

    // Next-state and next-output logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_last_nxt    = r_last;
        w_owner_nxt   = r_owner;
        w_dir_nxt     = r_dir;
        w_remain_nxt  = r_remain;
        w_out_nxt     = r_out;
        w_wrap_nxt    = 1'b0;
        w_grant_nxt   = r_grant;
        w_done_nxt    = 1'b0;
        w_done_id_nxt = r_done_id;
        w_aborted_nxt = r_aborted;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt = w_winner;
                    w_last_nxt  = w_winner;
                    w_dir_nxt   = dir[w_winner];
                    if (w_len_sel != {LEN_W{1'b0}}) begin
                        w_state_nxt  = ST_RUN;
                        w_remain_nxt = w_len_sel;
                        w_grant_nxt  = w_winner_onehot;
                    end else begin
                        // Zero-length burst completes without ever granting.
                        w_state_nxt   = ST_DONE;
                        w_remain_nxt  = {LEN_W{1'b0}};
                        w_grant_nxt   = {NREQ{1'b0}};
                        w_done_nxt    = 1'b1;
                        w_done_id_nxt = w_winner;
                        w_aborted_nxt = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = {NREQ{1'b0}};
                end
            end

            ST_RUN: begin
                if (!req[r_owner]) begin
                    // Owner withdrew: finish without stepping on this edge.
                    w_state_nxt   = ST_DONE;
                    w_grant_nxt   = {NREQ{1'b0}};
                    w_done_nxt    = 1'b1;
                    w_done_id_nxt = r_owner;
                    w_aborted_nxt = 1'b1;
                end else begin
                    w_out_nxt    = step_value(r_out, r_dir);
                    w_wrap_nxt   = step_wraps(r_out, r_dir);
                    w_remain_nxt = r_remain - {{(LEN_W-1){1'b0}}, 1'b1};
                    if (r_remain == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                        w_state_nxt   = ST_DONE;
                        w_grant_nxt   = {NREQ{1'b0}};
                        w_done_nxt    = 1'b1;
                        w_done_id_nxt = r_owner;
                        w_aborted_nxt = 1'b0;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end

            ST_DONE: begin
                // Requests seen here are left for the next IDLE cycle.
                w_state_nxt = ST_IDLE;
                w_grant_nxt = {NREQ{1'b0}};
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = {NREQ{1'b0}};
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_last    <= LAST_RST;
            r_owner   <= {IDW{1'b0}};
            r_dir     <= 1'b0;
            r_remain  <= {LEN_W{1'b0}};
            r_out     <= {WIDTH{1'b0}};
            r_wrap    <= 1'b0;
            r_grant   <= {NREQ{1'b0}};
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_done_id <= {IDW{1'b0}};
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_owner   <= w_owner_nxt;
            r_dir     <= w_dir_nxt;
            r_remain  <= w_remain_nxt;
            r_out     <= w_out_nxt;
            r_wrap    <= w_wrap_nxt;
            r_grant   <= w_grant_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= w_done_nxt;
            r_done_id <= w_done_id_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    assign grant   = r_grant;
    assign busy    = r_busy;
    assign done    = r_done;
    assign done_id = r_done_id;
    assign aborted = r_aborted;
    assign out     = r_out;
    assign wrap    = r_wrap;

endmodule

// File: tb/tb_count_sched.sv
// -----------------------------------------------------------------------------
// tb_count_sched
// Directed stimulus for count_sched with a scoreboard: each burst issued pushes
// its expected completion record (owner, aborted, final out, grant cycles,
// wrap pulses); a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_count_sched;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] dir;
    logic [7:0] len;
    logic [1:0] grant;
    logic       busy;
    logic       done;
    logic [0:0] done_id;
    logic       aborted;
    logic [3:0] out;
    logic       wrap;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [0:0] id;
        logic       ab;
        logic [3:0] val;
        int         gcyc;
        int         wraps;
    } exp_t;

    exp_t sb[$];
    int   m_gcyc  = 0;
    int   m_wraps = 0;

    count_sched #(.NREQ(2), .WIDTH(4), .LEN_W(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .dir     (dir),
        .len     (len),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .aborted (aborted),
        .out     (out),
        .wrap    (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [0:0] id, input logic ab, input logic [3:0] v,
                        input int g, input int w);
        exp_t e;
        e.id = id; e.ab = ab; e.val = v; e.gcyc = g; e.wraps = w;
        sb.push_back(e);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 200 cycles");
        end
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        @(negedge clk);
        while (grant == 2'b00 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (grant == 2'b00) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no grant expected grant within 50 cycles");
        end
    endtask

    // Monitor: accumulate grant cycles and wrap pulses, compare on each done.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            m_gcyc  = 0;
            m_wraps = 0;
        end else begin
            if (grant != 2'b00) m_gcyc++;
            if (wrap) m_wraps++;
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done id=%0d expected none", done_id);
                end else begin
                    e = sb.pop_front();
                    chk("done_id", 32'(done_id), 32'(e.id));
                    chk("aborted", 32'(aborted), 32'(e.ab));
                    chk("out_at_done", 32'(out), 32'(e.val));
                    chk("grant_cycles", 32'(m_gcyc), 32'(e.gcyc));
                    chk("wrap_pulses", 32'(m_wraps), 32'(e.wraps));
                    chk("busy_at_done", 32'(busy), 32'd1);
                end
                m_gcyc  = 0;
                m_wraps = 0;
            end
        end
    end

    initial begin
        reset = 1'b0;
        req   = 2'b00;
        dir   = 2'b00;
        len   = 8'h00;
        #12;
        chk("rst_out", 32'(out), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single up burst; dir/len changes after grant must be ignored.
        push(1'b0, 1'b0, 4'd5, 5, 0);
        req = 2'b01; dir = 2'b00; len = 8'h05;
        wait_grant();
        chk("grant_r0", 32'(grant), 32'd1);
        dir = 2'b11; len = 8'h11;
        wait_done();
        req = 2'b00; dir = 2'b00; len = 8'h00;
        @(negedge clk);
        chk("grant_after_done", 32'(grant), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);

        // Bring out back to 0, then a down burst that wraps on the first step.
        push(1'b1, 1'b0, 4'd0, 5, 0);
        req = 2'b10; dir = 2'b10; len = 8'h50;
        wait_done();
        req = 2'b00;
        repeat (2) @(negedge clk);
        push(1'b1, 1'b0, 4'd13, 3, 1);
        req = 2'b10; dir = 2'b10; len = 8'h30;
        wait_done();
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Round robin with both requesting; last owner was 1, so 0 goes first.
        push(1'b0, 1'b0, 4'd15, 2, 0);
        push(1'b1, 1'b0, 4'd1, 2, 1);
        push(1'b0, 1'b0, 4'd3, 2, 0);
        req = 2'b11; dir = 2'b00; len = 8'h22;
        wait_done();
        wait_done();
        wait_done();
        req = 2'b00;
        repeat (2) @(negedge clk);

        // Move out to 7, then a zero-length burst: no grant, out holds.
        push(1'b0, 1'b0, 4'd7, 4, 0);
        req = 2'b01; dir = 2'b00; len = 8'h04;
        wait_done();
        req = 2'b00;
        repeat (2) @(negedge clk);
        push(1'b0, 1'b0, 4'd7, 0, 0);
        req = 2'b01; len = 8'h00;
        wait_done();
        req = 2'b00;
        repeat (2) @(negedge clk);
        chk("out_after_zero_len", 32'(out), 32'd7);

        // Abort after three steps of a ten-step burst.
        push(1'b0, 1'b1, 4'd10, 4, 0);
        req = 2'b01; dir = 2'b00; len = 8'h0A;
        wait_grant();
        repeat (3) @(negedge clk);
        req = 2'b00;
        wait_done();
        @(negedge clk);
        chk("out_after_abort", 32'(out), 32'd10);
        chk("grant_after_abort", 32'(grant), 32'd0);

        // Asynchronous reset in the middle of a burst.
        req = 2'b10; dir = 2'b00; len = 8'h80;
        wait_grant();
        repeat (2) @(negedge clk);
        chk("out_before_reset", 32'(out), 32'd12);
        #1 reset = 1'b0;
        #1;
        chk("async_rst_out", 32'(out), 32'd0);
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_done", 32'(done), 32'd0);
        req = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // After reset requester 0 has priority.
        push(1'b0, 1'b0, 4'd1, 1, 0);
        push(1'b1, 1'b0, 4'd2, 1, 0);
        req = 2'b11; dir = 2'b00; len = 8'h11;
        wait_done();
        wait_done();
        req = 2'b00;
        repeat (4) @(negedge clk);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_sched.md
Name: count_sched

Overview:
- Round-robin scheduler that shares one WIDTH-bit up/down counter between NREQ requesters.
- Each requester asks for a burst of LEN single steps in one direction. The block grants the counter to one requester and sequences the burst.
- It signals completion and holds the counter value between bursts.
- It sits between control agents and the shared counter datapath, and contains that datapath internally.

Parameters:
- NREQ, 2, number of requesters (>=2).
- WIDTH, 4, counter width.
- LEN_W, 4, width of each burst-length field.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req  in  NREQ  per-requester request level; must be held until done for that requester.
- dir  in  NREQ  per-requester direction: 0 = count up, 1 = count down; sampled at grant.
- len  in  NREQ*LEN_W  per-requester burst length; requester i uses bits [i*LEN_W +: LEN_W]; sampled at grant.
- grant  out  NREQ  one-hot owner of the counter; high during RUN only.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle completion pulse.
- done_id  out  clog2(NREQ)  index of the requester being completed; valid when done=1.
- aborted  out  1  valid with done; 1 if the burst was cut short by req dropping.
- out  out  WIDTH  shared counter value.
- wrap  out  1  one-cycle pulse on the edge where out wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - State=IDLE.
  - out=0; grant=0; busy=0; done=0; done_id=0; aborted=0; wrap=0.
  - Round-robin pointer last=NREQ-1, so requester 0 has first priority.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req!=0, select the first asserted req searching from index last+1 upward, wrapping modulo NREQ.
  - On the edge, capture the winner's dir and len. Set grant[winner]=1 and last=winner.
  - If the captured len!=0, go to RUN with remain=len.
  - If the captured len==0, go straight to DONE with aborted=0; grant is never asserted and out is unchanged.
  - If req==0, stay in IDLE; out holds.
- RUN:
  - On each edge, out <= out+1 (dir=0) or out-1 (dir=1), modulo 2^WIDTH, and remain <= remain-1.
  - The edge on which remain==1 performs the last step. Transition to DONE and clear grant.
  - A LEN of N therefore gives exactly N steps, on the N edges following the grant edge.
- Abort: if req[owner]==0 is sampled in RUN, no step occurs on that edge. Go to DONE with aborted=1 and clear grant; out keeps its last value.
- DONE:
  - Exactly one cycle with done=1, done_id=owner, and aborted as set on entry.
  - Then return to IDLE; arbitration resumes on the following cycle.
  - A req still high in the DONE cycle is ignored and is re-arbitrated from IDLE.
- wrap:
  - Registered and coincident with the out update.
  - Set when an up-step goes from 2^WIDTH-1 to 0, or a down-step goes from 0 to 2^WIDTH-1; 0 otherwise.
- Outputs are registered and glitch-free; done and wrap are never high for more than one consecutive cycle per event.
- dir/len changes after grant have no effect on the running burst.
- Simultaneous requests are resolved by round-robin only. The last owner has the lowest priority in the next arbitration.
- Reset asserted mid-burst aborts silently: no done pulse, and all outputs return to reset values immediately.
- Back-to-back throughput: minimum IDLE→RUN→DONE→IDLE overhead is 2 cycles per burst, in addition to the LEN steps.

Test Plan:
- Single up burst: after reset, req=01, dir[0]=0, len0=5 → grant=01 for 5 cycles; out steps 1,2,3,4,5; done=1 with done_id=0 and aborted=0 the cycle after; grant=00.
- Down wrap: out=0, req=10, dir[1]=1, len1=3 → out=15,14,13; wrap=1 only on the 0→15 edge; done_id=1.
- Round robin: req=11 held, len=2 each, dir up → grant order is 01, then 10, then 01; out ends at 6 after three bursts; one done pulse per burst.
- Zero length: req=01, len0=0, out=7 → no grant; done=1 with done_id=0 two cycles after req; out stays 7.
- Abort: req=01, len0=10; drop req after 3 steps → out=3; next edge gives done=1, aborted=1, grant=00; out holds 3.
- Async reset mid-burst: pull reset=0 between clock edges during RUN with out=4 → out=0, grant=00, busy=0 immediately; no done pulse; after release, req=10 wins first.
